// File: rtl/stdp_learning_unit.sv
// stdp_learning_unit: pair-based STDP weight update between a pre- and a
// post-synaptic spike train. Spike times are tracked with saturating timers;
// each spike starts a one-cycle evaluation that applies a decaying LTP/LTD
// delta to the weight, clamped to [0, W_MAX].
// Optional build macro STDP_LEARN_GATE_EN adds a learn_en input that freezes
// the weight (timers and time_diff keep running).
module stdp_learning_unit #(
  parameter int W_W       = 8,
  parameter int CNT_W     = 8,
  parameter int W_INIT    = 128,
  parameter int W_MAX     = 255,
  parameter int A_PLUS    = 16,
  parameter int A_MINUS   = 16,
  parameter int TAU_SHIFT = 2,
  parameter int WINDOW    = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pre_spike,
  input  logic             post_spike,
`ifdef STDP_LEARN_GATE_EN
  input  logic             learn_en,
`endif
  output logic [W_W-1:0]   weight,
  output logic [CNT_W-1:0] time_diff,
  output logic             update_w_flag,
  output logic             update_dir
);

  localparam int SW = W_W + CNT_W + 2;
  localparam logic [CNT_W-1:0]      CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]      WIN      = CNT_W'(WINDOW);
  localparam logic signed [SW-1:0]  W_MAX_S  = SW'(W_MAX);

  typedef enum logic {IDLE, EVAL} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt_pre;
  logic [CNT_W-1:0]       cnt_post;
  logic                   pre_seen;
  logic                   post_seen;
  logic [CNT_W-1:0]       dt_p1;
  logic                   dir_p1;
  logic                   ok_p1;
  logic signed [CNT_W:0]  delta_p1;
  logic [W_W-1:0]         w_next_p1;
  logic                   in_win_p1;
  logic                   do_upd_p1;
  logic                   learn_act;

`ifdef STDP_LEARN_GATE_EN
  assign learn_act = learn_en;
`else
  assign learn_act = 1'b1;
`endif

  // Decaying amplitude A - (dt >> TAU_SHIFT), floored at zero.
  function automatic logic signed [CNT_W:0] calc_delta(input logic up,
                                                       input logic [CNT_W-1:0] dt);
    logic signed [CNT_W:0] amp;
    logic signed [CNT_W:0] decay;
    logic signed [CNT_W:0] diff;
    amp   = up ? (CNT_W+1)'(A_PLUS) : (CNT_W+1)'(A_MINUS);
    decay = $signed({1'b0, dt >> TAU_SHIFT});
    diff  = amp - decay;
    return (diff < 0) ? '0 : diff;
  endfunction

  // Add or subtract delta in a wide signed domain, then saturate to [0, W_MAX].
  function automatic logic [W_W-1:0] clamp_weight(input logic [W_W-1:0] w,
                                                   input logic signed [CNT_W:0] d,
                                                   input logic up);
    logic signed [SW-1:0] ws;
    logic signed [SW-1:0] ds;
    logic signed [SW-1:0] sum;
    ws  = $signed({{(CNT_W+2){1'b0}}, w});
    ds  = $signed({{(W_W+1){d[CNT_W]}}, d});
    sum = up ? (ws + ds) : (ws - ds);
    if (sum > W_MAX_S)
      return W_W'(W_MAX);
    else if (sum < 0)
      return '0;
    else
      return sum[W_W-1:0];
  endfunction

  // Spike timers: reload to 1 on a spike, otherwise count up and saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_pre   <= '0;
      cnt_post  <= '0;
      pre_seen  <= 1'b0;
      post_seen <= 1'b0;
    end else begin
      if (pre_spike) begin
        cnt_pre  <= CNT_W'(1);
        pre_seen <= 1'b1;
      end else if (cnt_pre != CNT_MAX) begin
        cnt_pre <= cnt_pre + CNT_W'(1);
      end
      if (post_spike) begin
        cnt_post  <= CNT_W'(1);
        post_seen <= 1'b1;
      end else if (cnt_post != CNT_MAX) begin
        cnt_post <= cnt_post + CNT_W'(1);
      end
    end
  end

  // Evaluation stage: delta, clamped weight and the qualifying conditions.
  always_comb begin
    delta_p1  = calc_delta(dir_p1, dt_p1);
    w_next_p1 = clamp_weight(weight, delta_p1, dir_p1);
    in_win_p1 = ok_p1 && (dt_p1 != '0) && (dt_p1 <= WIN) && (dt_p1 != CNT_MAX);
    do_upd_p1 = in_win_p1 && (delta_p1 != '0) && learn_act && (w_next_p1 != weight);
  end

  // IDLE/EVAL controller. A spike arriving while in EVAL is captured straight
  // into the pairing registers, so it is evaluated on the very next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      dt_p1         <= '0;
      dir_p1        <= 1'b0;
      ok_p1         <= 1'b0;
      weight        <= W_W'(W_INIT);
      time_diff     <= '0;
      update_w_flag <= 1'b0;
      update_dir    <= 1'b0;
    end else begin
      update_w_flag <= 1'b0;
      if (state == EVAL) begin
        if (ok_p1)
          time_diff <= dt_p1;
        if (do_upd_p1) begin
          weight        <= w_next_p1;
          update_w_flag <= 1'b1;
          update_dir    <= dir_p1;
        end
      end
      // Coincident spikes evaluate as dt=0: time_diff clears, weight holds.
      if (pre_spike && post_spike) begin
        dt_p1  <= '0;
        dir_p1 <= 1'b0;
        ok_p1  <= 1'b1;
        state  <= EVAL;
      end else if (post_spike) begin
        dt_p1  <= cnt_pre;
        dir_p1 <= 1'b1;
        ok_p1  <= pre_seen;
        state  <= EVAL;
      end else if (pre_spike) begin
        dt_p1  <= cnt_post;
        dir_p1 <= 1'b0;
        ok_p1  <= post_seen;
        state  <= EVAL;
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule
